// File: rtl/sap_pkg.sv
// Shared definitions for the SAP output path: shifter FSM states and the default word width.
package sap_pkg;

    localparam int unsigned SAP_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sap_state_e;

endpackage

// File: rtl/out_hold_reg.sv
// One-entry holding register between the W-bus and the shifter.
// A load is accepted while empty, or when the current word leaves on the same edge.
module out_hold_reg
    import sap_pkg::*;
#(
    parameter int unsigned W = SAP_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    input  logic         xfer_i,
    output logic         full_o,
    output logic [W-1:0] hold_o,
    output logic         drop_o
);

    logic         full_q, full_d;
    logic [W-1:0] hold_q, hold_d;
    logic         accept;

    always_comb begin
        accept = load_i && (!full_q || xfer_i);
        hold_d = hold_q;
        full_d = full_q;
        if (xfer_i) begin
            full_d = 1'b0;
        end
        // A same-edge load wins over the transfer, so full stays set.
        if (accept) begin
            hold_d = d_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            hold_q <= '0;
        end else begin
            full_q <= full_d;
            hold_q <= hold_d;
        end
    end

    assign full_o = full_q;
    assign hold_o = hold_q;
    assign drop_o = load_i && !accept;

endmodule

// File: rtl/out_shift_reg.sv
// Bus-side reader: captures a word on i_en and drains it MSB first over a valid/ready
// serial link, with a holding register giving two-word buffering.
module out_shift_reg
    import sap_pkg::*;
#(
    parameter int unsigned W = SAP_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         i_en,
    input  logic [W-1:0] d,
    output logic         full,
    output logic         busy,
    output logic         ovf,
    output logic         ser_data,
    output logic         ser_valid,
    output logic         ser_last,
    input  logic         ser_ready
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    sap_state_e    state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  hold;
    logic          drop;
    logic          xfer;
    logic          shifting;
    logic          is_last;

    assign shifting = (state_q == ST_SHIFT);
    assign is_last  = shifting && (cnt_q == LastCnt);
    // Hold moves into the shifter when idle, or right behind the last bit (no bubble).
    assign xfer     = full && (!shifting || (ser_ready && is_last));

    out_hold_reg #(
        .W (W)
    ) u_hold (
        .clk_i  (clk),
        .rst_ni (clr),
        .load_i (i_en),
        .d_i    (d),
        .xfer_i (xfer),
        .full_o (full),
        .hold_o (hold),
        .drop_o (drop)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | drop;
        unique case (state_q)
            ST_IDLE: begin
                if (full) begin
                    state_d = ST_SHIFT;
                    shreg_d = hold;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    if (!is_last) begin
                        shreg_d = {shreg_q[W-2:0], 1'b0};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (full) begin
                        shreg_d = hold;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = shifting;
    assign ovf       = ovf_q;
    assign ser_valid = shifting;
    assign ser_data  = shifting & shreg_q[W-1];
    assign ser_last  = is_last;

endmodule

// File: tb/tb_out_shift_reg.sv
// Bench for out_shift_reg: directed scenarios plus random traffic against a word-level model
// and a scoreboard that reassembles the serial stream into words.
module tb_out_shift_reg;

    localparam int unsigned W = 4;

    logic         clk;
    logic         clr;
    logic         i_en;
    logic [W-1:0] d;
    logic         full;
    logic         busy;
    logic         ovf;
    logic         ser_data;
    logic         ser_valid;
    logic         ser_last;
    logic         ser_ready;

    out_shift_reg #(
        .W (W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .i_en      (i_en),
        .d         (d),
        .full      (full),
        .busy      (busy),
        .ovf       (ovf),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .ser_ready (ser_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Word-level model: the word on the wire with its bit index, plus the pending word.
    bit           m_cur_v;
    logic [W-1:0] m_cur_w;
    int           m_idx;
    bit           m_hold_v;
    logic [W-1:0] m_hold_w;
    bit           m_ovf;

    logic [W-1:0] exp_words[$];
    logic [W-1:0] rx_word;
    int           rx_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cur_v  = 0;
        m_cur_w  = '0;
        m_idx    = 0;
        m_hold_v = 0;
        m_hold_w = '0;
        m_ovf    = 0;
        exp_words.delete();
        rx_word  = '0;
        rx_cnt   = 0;
    endtask

    task automatic model_step(input logic en, input logic [W-1:0] dv, input logic rdy);
        bit last, xf, acc;
        last = m_cur_v && (m_idx == W - 1);
        xf   = m_hold_v && (!m_cur_v || (rdy && last));
        acc  = en && (!m_hold_v || xf);
        if (m_cur_v && rdy) begin
            if (last) m_cur_v = 0;
            else m_idx++;
        end
        if (xf) begin
            m_cur_v  = 1;
            m_cur_w  = m_hold_w;
            m_idx    = 0;
            m_hold_v = 0;
        end
        if (acc) begin
            m_hold_v = 1;
            m_hold_w = dv;
            exp_words.push_back(dv);
        end else if (en) begin
            m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        logic exp_bit;
        exp_bit = m_cur_v ? m_cur_w[W-1-m_idx] : 1'b0;
        check("full", 32'(full), 32'(m_hold_v));
        check("busy", 32'(busy), 32'(m_cur_v));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("ser_valid", 32'(ser_valid), 32'(m_cur_v));
        check("ser_data", 32'(ser_data), 32'(exp_bit));
        check("ser_last", 32'(ser_last), 32'(m_cur_v && (m_idx == W - 1)));
    endtask

    // Called at a negedge: drive inputs, collect the bit handshaken at the coming edge,
    // advance the model at the edge and compare at the next negedge.
    task automatic cycle(input logic en, input logic [W-1:0] dv, input logic rdy);
        logic [W-1:0] want;
        i_en      = en;
        d         = dv;
        ser_ready = rdy;
        if (ser_valid && rdy) begin
            rx_word = {rx_word[W-2:0], ser_data};
            rx_cnt++;
            if (ser_last) begin
                check("sb_len", 32'(rx_cnt), 32'(W));
                check("sb_pending", 32'(exp_words.size() != 0), 32'd1);
                if (exp_words.size() != 0) begin
                    want = exp_words.pop_front();
                    check("sb_word", 32'(rx_word), 32'(want));
                end
                rx_cnt  = 0;
                rx_word = '0;
            end
        end
        @(posedge clk);
        model_step(en, dv, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy);
    endtask

    task automatic async_reset();
        i_en = 1'b0;
        #2 clr = 1'b0;
        #1;
        check("arst_full", 32'(full), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_valid", 32'(ser_valid), 32'd0);
        check("arst_data", 32'(ser_data), 32'd0);
        check("arst_last", 32'(ser_last), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        check_outputs();
    endtask

    initial begin
        clr       = 1'b0;
        i_en      = 1'b0;
        d         = '0;
        ser_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        clr = 1'b1;

        // Single word
        cycle(1'b1, 4'hA, 1'b1);
        idle(6, 1'b1);

        // Back-to-back words, no valid gap
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b1, 4'h4, 1'b1);
        idle(10, 1'b1);

        // Backpressure
        cycle(1'b1, 4'hC, 1'b0);
        idle(6, 1'b0);
        idle(6, 1'b1);

        // Overrun, then drain
        cycle(1'b1, 4'hE, 1'b0);
        cycle(1'b1, 4'h4, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        idle(3, 1'b0);
        idle(12, 1'b1);

        // Load on the same edge as the last-bit handshake while hold is full
        async_reset();
        cycle(1'b1, 4'h8, 1'b1);
        cycle(1'b1, 4'h3, 1'b1);
        idle(3, 1'b1);
        cycle(1'b1, 4'h5, 1'b1);
        idle(12, 1'b1);

        // Reset mid-word, then silence until the next load
        cycle(1'b1, 4'hA, 1'b1);
        idle(3, 1'b1);
        async_reset();
        idle(4, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                cycle(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, W'($urandom),
                      ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
            end
        end
        idle(20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
